// File: rtl/vx_table_initiator.sv
// Initiator for the lookup-table action protocol: one host request at a time is turned into
// one or two table actions (UPSERT = PRESENT then UPDATE/ADD), with timeout and illegal-op checks.
module vx_table_initiator #(
    parameter int ADDRW   = 4,
    parameter int DATAW   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [DATAW-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [DATAW-1:0] rsp_data,
    output logic [1:0]       rsp_err,
    output logic             tbl_valid,
    output logic [2:0]       tbl_action,
    output logic [ADDRW-1:0] tbl_addr,
    output logic [DATAW-1:0] tbl_data,
    input  logic             tbl_done,
    input  logic             tbl_hit,
    input  logic [DATAW-1:0] tbl_rdata,
    input  logic             tbl_full
);
    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT);

    localparam logic [2:0] OP_PRESENT = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_UPDATE  = 3'd2;
    localparam logic [2:0] OP_GET     = 3'd4;
    localparam logic [2:0] OP_UPSERT  = 3'd5;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_FULL    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       act_q, act_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [DATAW-1:0] data_q, data_d;
    logic             ph2_q, ph2_d;
    logic             p1hit_q, p1hit_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             rhit_q, rhit_d;
    logic [DATAW-1:0] rdata_q, rdata_d;
    logic [1:0]       rerr_q, rerr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            act_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ph2_q   <= 1'b0;
            p1hit_q <= 1'b0;
            cnt_q   <= '0;
            rhit_q  <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= '0;
        end else begin
            op_q    <= op_d;
            act_q   <= act_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ph2_q   <= ph2_d;
            p1hit_q <= p1hit_d;
            cnt_q   <= cnt_d;
            rhit_q  <= rhit_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        act_d   = act_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ph2_d   = ph2_q;
        p1hit_d = p1hit_q;
        cnt_d   = cnt_q;
        rhit_d  = rhit_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    data_d  = req_data;
                    ph2_d   = 1'b0;
                    p1hit_d = 1'b0;
                    rhit_d  = 1'b0;
                    rdata_d = '0;
                    rerr_d  = ERR_OK;
                    if (req_op > OP_UPSERT) begin
                        rerr_d  = ERR_ILLEGAL;
                        state_d = S_RESP;
                    end else if (req_op == OP_ADD && tbl_full) begin
                        rerr_d  = ERR_FULL;
                        state_d = S_RESP;
                    end else begin
                        act_d   = (req_op == OP_UPSERT) ? OP_PRESENT : req_op;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done in the same cycle the counter reaches TIMEOUT still counts as success.
                if (tbl_done) begin
                    if (op_q == OP_UPSERT && !ph2_q) begin
                        ph2_d   = 1'b1;
                        p1hit_d = tbl_hit;
                        if (tbl_hit) begin
                            act_d   = OP_UPDATE;
                            state_d = S_ISSUE;
                        end else if (tbl_full) begin
                            rerr_d  = ERR_FULL;
                            state_d = S_RESP;
                        end else begin
                            act_d   = OP_ADD;
                            state_d = S_ISSUE;
                        end
                    end else begin
                        rhit_d  = (op_q == OP_PRESENT) ? tbl_hit :
                                  (op_q == OP_UPSERT)  ? p1hit_q : 1'b0;
                        rdata_d = (op_q == OP_GET) ? tbl_rdata : '0;
                        rerr_d  = ERR_OK;
                        state_d = S_RESP;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    rerr_d  = ERR_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        tbl_valid  = (state_q == S_ISSUE);
        rsp_valid  = (state_q == S_RESP);
        rsp_hit    = rhit_q;
        rsp_data   = rdata_q;
        rsp_err    = rerr_q;
        tbl_action = act_q;
        tbl_addr   = addr_q;
        tbl_data   = data_q;
    end
endmodule

// File: tb/tb_vx_table_initiator.sv
// Bench for vx_table_initiator: table-driven request vectors against a behavioural table
// responder, plus hand-written timeout and reset-abort sequences.
module tb_vx_table_initiator;
    localparam int ADDRW = 4, DATAW = 4, TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_hit;
    logic [2:0] req_op, tbl_action;
    logic [3:0] req_addr, req_data, rsp_data, tbl_addr, tbl_data, tbl_rdata;
    logic [1:0] rsp_err;
    logic tbl_valid, tbl_done, tbl_hit, tbl_full;

    vx_table_initiator #(.ADDRW(ADDRW), .DATAW(DATAW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .tbl_valid(tbl_valid),
        .tbl_action(tbl_action), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .tbl_done(tbl_done), .tbl_hit(tbl_hit), .tbl_rdata(tbl_rdata), .tbl_full(tbl_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op; logic [3:0] addr; logic [3:0] data;
        int delay; logic hit1; logic hit2; logic [3:0] rdata; logic full; int rdy;
        logic ehit; logic [3:0] edata; logic [1:0] eerr;
        int nstb; logic [2:0] act1; logic [2:0] act2; int lat;
    } vec_t;
    typedef struct packed { logic hit; logic [3:0] data; logic [1:0] err; } rsp_t;
    typedef struct packed { logic [2:0] act; logic [3:0] addr; logic [3:0] data; } stb_t;

    rsp_t exp_q[$];
    stb_t stb_log[$];
    vec_t vecs[15];

    int n_tests = 0, n_fail = 0;
    // Responder configuration, written only by the main process.
    int cfg_delay = 0, cfg_gen = 0, stray_req = 0;
    logic cfg_hit1 = 0, cfg_hit2 = 0;
    logic [3:0] cfg_rdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] addr, input logic [3:0] data,
                                input int delay, input logic hit1, input logic hit2,
                                input logic [3:0] rdata, input logic full, input int rdy,
                                input logic ehit, input logic [3:0] edata, input logic [1:0] eerr,
                                input int nstb, input logic [2:0] act1, input logic [2:0] act2,
                                input int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.delay = delay; v.hit1 = hit1; v.hit2 = hit2;
        v.rdata = rdata; v.full = full; v.rdy = rdy; v.ehit = ehit; v.edata = edata;
        v.eerr = eerr; v.nstb = nstb; v.act1 = act1; v.act2 = act2; v.lat = lat;
        return v;
    endfunction

    // Behavioural table: answers each strobe with done after cfg_delay cycles (0 = never).
    initial begin
        int pend, gen_seen, nloc, stray_seen;
        stb_t s;
        pend = 0; gen_seen = -1; nloc = 0; stray_seen = 0;
        tbl_done = 0; tbl_hit = 0; tbl_rdata = 0;
        forever begin
            @(negedge clk);
            tbl_done = 0; tbl_hit = 0; tbl_rdata = 0;
            if (reset) pend = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    tbl_done = 1; tbl_hit = (nloc <= 1) ? cfg_hit1 : cfg_hit2; tbl_rdata = cfg_rdata;
                end
            end else if (stray_seen != stray_req) begin
                stray_seen = stray_req;
                tbl_done = 1; tbl_hit = 1; tbl_rdata = 4'hF;
            end
            if (tbl_valid) begin
                if (gen_seen != cfg_gen) begin gen_seen = cfg_gen; nloc = 0; end
                nloc++;
                s.act = tbl_action; s.addr = tbl_addr; s.data = tbl_data;
                stb_log.push_back(s);
                if (cfg_delay > 0) pend = cfg_delay;
            end
        end
    end

    task automatic send_req(input logic [2:0] op, input logic [3:0] addr, input logic [3:0] data);
        int n;
        @(negedge clk);
        req_valid = 1; req_op = op; req_addr = addr; req_data = data;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 0;
    endtask

    // Returns cycles from accept to rsp_valid (first negedge after accept counts as 1).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    endtask

    task automatic check_rsp(input string tag);
        rsp_t e, a;
        a = '{rsp_hit, rsp_data, rsp_err};
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_rsp_hit"}, {31'd0, a.hit}, {31'd0, e.hit});
            chk({tag, "_rsp_data"}, {28'd0, a.data}, {28'd0, e.data});
            chk({tag, "_rsp_err"}, {30'd0, a.err}, {30'd0, e.err});
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk({tag, "_rsp_dropped"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base, lat;
        logic [6:0] snap;
        string tag;
        tag = $sformatf("v%0d", idx);
        cfg_delay = v.delay; cfg_hit1 = v.hit1; cfg_hit2 = v.hit2; cfg_rdata = v.rdata;
        cfg_gen++;
        tbl_full = v.full;
        base = stb_log.size();
        exp_q.push_back('{v.ehit, v.edata, v.eerr});
        send_req(v.op, v.addr, v.data);
        wait_rsp(lat);
        chk({tag, "_latency"}, lat, v.lat);
        if (v.rdy > 0) begin
            snap = {rsp_hit, rsp_data, rsp_err};
            repeat (v.rdy) @(negedge clk);
            chk({tag, "_rsp_hold"}, {24'd0, rsp_valid, snap}, {24'd0, 1'b1, rsp_hit, rsp_data, rsp_err});
        end
        check_rsp(tag);
        chk({tag, "_strobes"}, stb_log.size() - base, v.nstb);
        if (v.nstb >= 1 && stb_log.size() > base)
            chk({tag, "_strobe1"}, {21'd0, stb_log[base]}, {21'd0, v.act1, v.addr, v.data});
        if (v.nstb >= 2 && stb_log.size() > base + 1)
            chk({tag, "_strobe2"}, {21'd0, stb_log[base+1]}, {21'd0, v.act2, v.addr, v.data});
    endtask

    initial begin
        int lat, base;
        logic seen;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, base;
        logic seen;
        //             op    a     d   dly h1 h2 rdata full rdy  ehit edata err nstb a1 a2 lat
        vecs[0]  = mk(3'd1, 4'h3, 4'h5, 2, 0, 0, 4'h0, 0, 0,   0, 4'h0, 2'd0, 1, 1, 0, 4);
        vecs[1]  = mk(3'd0, 4'h3, 4'h0, 1, 1, 0, 4'h0, 0, 0,   1, 4'h0, 2'd0, 1, 0, 0, 3);
        vecs[2]  = mk(3'd0, 4'h3, 4'h0, 1, 0, 0, 4'h0, 0, 0,   0, 4'h0, 2'd0, 1, 0, 0, 3);
        vecs[3]  = mk(3'd4, 4'h3, 4'h0, 1, 0, 0, 4'h5, 0, 4,   0, 4'h5, 2'd0, 1, 4, 0, 3);
        vecs[4]  = mk(3'd5, 4'h7, 4'h9, 1, 0, 1, 4'hF, 0, 0,   0, 4'h0, 2'd0, 2, 0, 1, 5);
        vecs[5]  = mk(3'd5, 4'h7, 4'h9, 2, 1, 0, 4'h0, 0, 0,   1, 4'h0, 2'd0, 2, 0, 2, 7);
        vecs[6]  = mk(3'd6, 4'h2, 4'h3, 1, 0, 0, 4'h0, 0, 0,   0, 4'h0, 2'd3, 0, 0, 0, 1);
        vecs[7]  = mk(3'd7, 4'h2, 4'h3, 1, 0, 0, 4'h0, 0, 0,   0, 4'h0, 2'd3, 0, 0, 0, 1);
        vecs[8]  = mk(3'd1, 4'h4, 4'h4, 1, 0, 0, 4'h0, 1, 0,   0, 4'h0, 2'd1, 0, 0, 0, 1);
        vecs[9]  = mk(3'd5, 4'h8, 4'h1, 1, 0, 0, 4'h0, 1, 0,   0, 4'h0, 2'd1, 1, 0, 0, 3);
        vecs[10] = mk(3'd2, 4'h2, 4'hA, 3, 1, 0, 4'h3, 0, 0,   0, 4'h0, 2'd0, 1, 2, 0, 5);
        vecs[11] = mk(3'd3, 4'h1, 4'h0, 1, 0, 0, 4'h0, 0, 0,   0, 4'h0, 2'd0, 1, 3, 0, 3);
        vecs[12] = mk(3'd4, 4'h6, 4'h0, 2, 1, 0, 4'hC, 0, 0,   0, 4'hC, 2'd0, 1, 4, 0, 4);
        vecs[13] = mk(3'd0, 4'h5, 4'h0, 16, 1, 0, 4'hF, 0, 0,  1, 4'h0, 2'd0, 1, 0, 0, 18);
        vecs[14] = mk(3'd5, 4'h9, 4'h2, 1, 1, 0, 4'h0, 1, 0,   1, 4'h0, 2'd0, 2, 0, 2, 5);

        reset = 1; req_valid = 0; req_op = 0; req_addr = 0; req_data = 0;
        rsp_ready = 0; tbl_full = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", {24'd0, rsp_valid, tbl_valid, req_ready, rsp_hit, rsp_err, tbl_action == 3'd0, 1'b0},
            {24'd0, 8'b0010_0010});
        reset = 0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Timeout: done never arrives; later stray dones must be ignored.
        cfg_delay = 0; cfg_gen++; tbl_full = 0;
        exp_q.push_back('{1'b0, 4'h0, 2'd2});
        send_req(3'd0, 4'h4, 4'h0);
        wait_rsp(lat);
        chk("timeout_latency", lat, 18);
        stray_req++;
        repeat (3) @(negedge clk);
        chk("timeout_hold", {28'd0, rsp_valid, rsp_hit, rsp_err}, {28'd0, 4'b1010});
        check_rsp("timeout");
        base = stb_log.size();
        stray_req++;
        seen = 0;
        repeat (4) begin @(negedge clk); seen |= rsp_valid | tbl_valid; end
        chk("late_done_ignored", {31'd0, seen}, 32'd0);
        chk("late_done_no_strobe", stb_log.size() - base, 0);

        // Reset in WAIT aborts the GET with no response.
        cfg_delay = 0; cfg_gen++;
        send_req(3'd4, 4'h5, 4'h6);
        repeat (3) @(negedge clk);
        chk("pre_reset_action", {29'd0, tbl_action}, 32'd4);
        reset = 1;
        @(negedge clk);
        chk("reset_outputs", {13'd0, rsp_valid, tbl_valid, rsp_hit, rsp_data, rsp_err, tbl_action, tbl_addr, tbl_data},
            32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        reset = 0;
        seen = 0;
        repeat (6) begin @(negedge clk); seen |= rsp_valid | ~req_ready; end
        chk("reset_no_response", {31'd0, seen}, 32'd0);

        run_vec(vecs[1], 15);
        run_vec(vecs[4], 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
